data_memory_param: RTL and testbench

Parametrised successor to the fixed 16x16 data memory in the single-cycle datapath.
- Generalised in word width and depth.
- Adds per-byte write enables, a registered read port with a valid strobe, and a post-reset hardware clear sweep with a ready flag.
- Sits between the ALU result/address path and the write-back mux; the control unit stalls on ready.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_byte_lane.sv | 54 +++++
 rtl/data_memory_param.sv | 161 ++++++++++++++++
 tb/tb_data_memory_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the parametrised data memory
//
// Contents:
//   dmem_state_e  : controller state (ST_CLEAR sweep, ST_RUN normal operation)
//   LANE_W        : bits per byte lane
//   nbyte_of()    : byte lanes per word for a given word width
//   lane_lo()     : lowest bit index of a byte lane inside a word
//   even_parity() : parity bit that makes a byte plus its bit even
// Optional feature macro used by the files importing this package:
//   DATA_MEMORY_PARAM_PARITY_EN
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    localparam int LANE_W = 8;

    function automatic int nbyte_of(input int data_w);
        return data_w / LANE_W;
    endfunction

    function automatic int lane_lo(input int lane);
        return lane * LANE_W;
    endfunction

    function automatic logic even_parity(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// rtl/dmem_byte_lane.sv - one 8-bit column of the data memory
//
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable for this lane
//   waddr  in   write word index (caller guarantees waddr < DEPTH when we=1)
//   wdata  in   lane write data
//   raddr  in   read word index (asynchronous read; caller masks out-of-range)
//   rdata  out  stored lane value at raddr
//   wpar   in   parity bit stored with wdata  (DATA_MEMORY_PARAM_PARITY_EN only)
//   rpar   out  stored parity bit at raddr    (DATA_MEMORY_PARAM_PARITY_EN only)
// Storage is not reset; the top-level clear sweep initialises it.
module dmem_byte_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
`ifdef DATA_MEMORY_PARAM_PARITY_EN
    ,
    input  logic              wpar,
    output logic              rpar
`endif
);

    logic [LANE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

`ifdef DATA_MEMORY_PARAM_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_q[waddr] <= wpar;
        end
    end

    assign rpar = par_q[raddr];
`endif

endmodule

// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - parametrised data memory with byte enables and clear sweep
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   mem_write   in   write request
//   mem_read    in   read request
//   address     in   word address
//   write_data  in   write data
//   byte_en     in   per-lane write enable
//   read_data   out  registered read data, held until the next accepted read
//   read_valid  out  one-cycle pulse per accepted read
//   ready       out  high once the post-reset clear sweep has finished
//   parity_err  out  registered parity mismatch flag (DATA_MEMORY_PARAM_PARITY_EN only)
// After reset release every word is zeroed, one per cycle, before requests are accepted.
module data_memory_param
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_write,
    input  logic                      mem_read,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         write_data,
    input  logic [DATA_W/LANE_W-1:0]  byte_en,
    output logic [DATA_W-1:0]         read_data,
    output logic                      read_valid,
    output logic                      ready
`ifdef DATA_MEMORY_PARAM_PARITY_EN
    ,
    output logic                      parity_err
`endif
);

    localparam int NBYTE = nbyte_of(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              clearing;
    logic              in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic [NBYTE-1:0]  lane_we;
    logic [NBYTE-1:0]  lane_fwd;
    logic [ADDR_W-1:0] lane_waddr;
    logic [LANE_W-1:0] lane_wdata [NBYTE];
    logic [LANE_W-1:0] lane_rdata [NBYTE];
    logic [DATA_W-1:0] merged;

    // One bit wider so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state logic: the counter stops on the last word and the FSM moves to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    // Output / datapath logic
    always_comb begin
        clearing   = (state_q == ST_CLEAR);
        ready      = (state_q == ST_RUN);
        wr_accept  = ready && mem_write && in_range;
        rd_accept  = ready && mem_read;
        lane_waddr = clearing ? cnt_q : address;
        merged     = '0;
        for (int i = 0; i < NBYTE; i++) begin
            lane_fwd[i]   = wr_accept && byte_en[i];
            lane_we[i]    = clearing || lane_fwd[i];
            lane_wdata[i] = clearing ? '0 : write_data[lane_lo(i) +: LANE_W];
            // Write-first: a lane written this cycle returns the new data.
            merged[lane_lo(i) +: LANE_W] = lane_fwd[i] ? write_data[lane_lo(i) +: LANE_W]
                                                        : lane_rdata[i];
        end
        rd_valid_d = rd_accept;
        rd_data_d  = rd_data_q;
        if (rd_accept) begin
            rd_data_d = in_range ? merged : '0;
        end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;

`ifdef DATA_MEMORY_PARAM_PARITY_EN
    logic [NBYTE-1:0] lane_wpar;
    logic [NBYTE-1:0] lane_rpar;
    logic             par_err_q, par_err_d;

    always_comb begin
        par_err_d = 1'b0;
        for (int i = 0; i < NBYTE; i++) begin
            lane_wpar[i] = even_parity(lane_wdata[i]);
            // Forwarded lanes bypass storage, so their stored parity is irrelevant.
            if (!lane_fwd[i] && (even_parity(lane_rdata[i]) != lane_rpar[i])) begin
                par_err_d = rd_accept && in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign parity_err = par_err_q;
`endif

    for (genvar g = 0; g < NBYTE; g++) begin : g_lane
        dmem_byte_lane #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[g]),
            .raddr (address),
            .rdata (lane_rdata[g])
`ifdef DATA_MEMORY_PARAM_PARITY_EN
            ,
            .wpar  (lane_wpar[g]),
            .rpar  (lane_rpar[g])
`endif
        );
    end

endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - self-checking bench for data_memory_param (DEPTH 16 and DEPTH 12)
module tb_data_memory_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_mem_write, a_mem_read;
    logic [3:0]  a_address;
    logic [15:0] a_write_data;
    logic [1:0]  a_byte_en;
    logic [15:0] a_read_data;
    logic        a_read_valid, a_ready;

    logic        b_mem_write, b_mem_read;
    logic [3:0]  b_address;
    logic [15:0] b_write_data;
    logic [1:0]  b_byte_en;
    logic [15:0] b_read_data;
    logic        b_read_valid, b_ready;

`ifdef DATA_MEMORY_PARAM_PARITY_EN
    logic        a_parity_err, b_parity_err;
`endif

    data_memory_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_write  (a_mem_write),
        .mem_read   (a_mem_read),
        .address    (a_address),
        .write_data (a_write_data),
        .byte_en    (a_byte_en),
        .read_data  (a_read_data),
        .read_valid (a_read_valid),
        .ready      (a_ready)
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        ,
        .parity_err (a_parity_err)
`endif
    );

    data_memory_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) u_dut12 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_write  (b_mem_write),
        .mem_read   (b_mem_read),
        .address    (b_address),
        .write_data (b_write_data),
        .byte_en    (b_byte_en),
        .read_data  (b_read_data),
        .read_valid (b_read_valid),
        .ready      (b_ready)
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        ,
        .parity_err (b_parity_err)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model for the DEPTH=16 instance: plain word array plus cycle count since reset release.
    logic [15:0] mem_m [16];
    logic [15:0] exp_rd_a;
    int          since_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        logic        rdy;
        logic        exp_v;
        logic [15:0] word;
        a_mem_write  = w;
        a_mem_read   = r;
        a_address    = a;
        a_write_data = d;
        a_byte_en    = be;
        rdy   = (since_rst >= 16);
        exp_v = rdy && r;
        word  = mem_m[a];
        if (rdy && w) begin
            for (int l = 0; l < 2; l++) begin
                if (be[l]) word[8*l +: 8] = d[8*l +: 8];
            end
            mem_m[a] = word;
        end
        if (exp_v) exp_rd_a = word;
        @(posedge clk);
        #1;
        since_rst++;
        chk("ready16", a_ready, since_rst >= 16);
        chk("ready12", b_ready, since_rst >= 12);
        chk("valid16", a_read_valid, exp_v);
        chk("rdata16", a_read_data, exp_rd_a);
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        chk("perr16", a_parity_err, 1'b0);
`endif
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         input logic exp_v, input logic [15:0] exp_d, input logic exp_perr);
        b_mem_write  = w;
        b_mem_read   = r;
        b_address    = a;
        b_write_data = d;
        b_byte_en    = be;
        @(posedge clk);
        #1;
        chk("valid12", b_read_valid, exp_v);
        chk("rdata12", b_read_data, exp_d);
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        chk("perr12", b_parity_err, exp_perr);
`else
        if (exp_perr) chk("perr12_unexpected", 1'b0, 1'b1);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rdata16", a_read_data, 16'h0);
        chk("rst_valid16", a_read_valid, 1'b0);
        chk("rst_ready16", a_ready, 1'b0);
        chk("rst_rdata12", b_read_data, 16'h0);
        chk("rst_ready12", b_ready, 1'b0);
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        chk("rst_perr16", a_parity_err, 1'b0);
`endif
        for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
        exp_rd_a = 16'h0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        since_rst = 0;
    endtask

    initial begin
        a_mem_write = 0; a_mem_read = 0; a_address = 0; a_write_data = 0; a_byte_en = 0;
        b_mem_write = 0; b_mem_read = 0; b_address = 0; b_write_data = 0; b_byte_en = 0;
        since_rst = 0;
        do_reset();

        // Requests during the sweep are ignored; ready rises after exactly 16 cycles.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'd0, 16'hFFFF, 2'b11);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 16'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);

        cyc(1'b1, 1'b0, 4'd3, 16'hBEEF, 2'b11);
        cyc(1'b0, 1'b1, 4'd3, 16'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);

        cyc(1'b1, 1'b0, 4'd5, 16'h1234, 2'b11);
        cyc(1'b1, 1'b1, 4'd5, 16'hABCD, 2'b01);
        chk("fwd_12CD", a_read_data, 16'h12CD);
        cyc(1'b0, 1'b1, 4'd5, 16'h0, 2'b00);
        chk("hold_12CD", a_read_data, 16'h12CD);
        cyc(1'b1, 1'b0, 4'd5, 16'h5555, 2'b00);
        cyc(1'b0, 1'b1, 4'd5, 16'h0, 2'b00);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom), 2'($urandom_range(0, 3)));
        end

        // Reset at cycle 7 of a sweep, after writes; the full sweep must rerun.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 16'($urandom) | 16'h1, 2'b11);
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 16'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);

        // DEPTH=12 instance: out-of-range writes drop, reads return zero with valid.
        cyc_b(1'b1, 1'b0, 4'd14, 16'h5A5A, 2'b11, 1'b0, 16'h0000, 1'b0);
        cyc_b(1'b0, 1'b1, 4'd14, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0);
        cyc_b(1'b0, 1'b1, 4'd2, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0);
        cyc_b(1'b1, 1'b1, 4'd11, 16'hC3C3, 2'b10, 1'b1, 16'hC300, 1'b0);
        cyc_b(1'b0, 1'b1, 4'd11, 16'h0, 2'b00, 1'b1, 16'hC300, 1'b0);
        cyc_b(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 16'hC300, 1'b0);
`ifdef DATA_MEMORY_PARAM_PARITY_EN
        force u_dut12.g_lane[0].u_lane.rpar = 1'b1;
        cyc_b(1'b0, 1'b1, 4'd2, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b1);
        release u_dut12.g_lane[0].u_lane.rpar;
        cyc_b(1'b0, 1'b1, 4'd2, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
